// File: rtl/pad_conv_feeder.sv
// Streams raw row-major pixels into a 3-byte window buffer, one zero-padded
// horizontal {left, centre, right} window per pixel, with per-window pulses.
module pad_conv_feeder #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] c,
  output logic [7:0] pix,
  output logic       win_valid,
  output logic [7:0] win_col,
  output logic [7:0] win_row,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
  localparam logic [7:0] PEN_COL  = 8'(IMG_W - 2);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_WR2  = 3'd5;
  localparam logic [2:0] S_WIN  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0] state, state_n;
  logic [7:0] lft, lft_n, ctr, ctr_n, rgt, rgt_n;
  logic [7:0] row, row_n, col, col_n;
  logic       load_r, load_r_n;
  logic [1:0] c_n;
  logic [7:0] pix_n, win_col_n, win_row_n;
  logic       in_ready_n, win_valid_n, busy_n, frame_done_n;

  // Next state and datapath; load_r selects whether the next pixel lands in R.
  always_comb begin
    state_n  = state;
    lft_n    = lft;
    ctr_n    = ctr;
    rgt_n    = rgt;
    row_n    = row;
    col_n    = col;
    load_r_n = load_r;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLR;
          row_n   = 8'd0;
          col_n   = 8'd0;
        end
      end
      S_CLR: begin
        lft_n    = 8'd0;
        load_r_n = 1'b0;
        state_n  = S_LOAD;
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          if (!load_r) begin
            ctr_n    = in_pix;
            load_r_n = 1'b1;
          end else begin
            rgt_n   = in_pix;
            state_n = S_WR0;
          end
        end
      end
      S_WR0: state_n = S_WR1;
      S_WR1: state_n = S_WR2;
      S_WR2: state_n = S_WIN;
      S_WIN: begin
        if (col == LAST_COL) begin
          if (row == LAST_ROW) begin
            state_n = S_DONE;
          end else begin
            row_n   = row + 8'd1;
            col_n   = 8'd0;
            state_n = S_CLR;
          end
        end else begin
          lft_n = ctr;
          ctr_n = rgt;
          col_n = col + 8'd1;
          if (col == PEN_COL) begin
            rgt_n   = 8'd0;
            state_n = S_WR0;
          end else begin
            load_r_n = 1'b1;
            state_n  = S_LOAD;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs registered for the state being entered; c/pix hold otherwise.
    c_n          = c;
    pix_n        = pix;
    win_col_n    = win_col;
    win_row_n    = win_row;
    case (state_n)
      S_CLR: begin c_n = 2'b11; pix_n = 8'd0;  end
      S_WR0: begin c_n = 2'b00; pix_n = lft_n; end
      S_WR1: begin c_n = 2'b10; pix_n = ctr_n; end
      S_WR2: begin c_n = 2'b01; pix_n = rgt_n; end
      S_WIN: begin win_col_n = col_n; win_row_n = row_n; end
      default: ;
    endcase
    in_ready_n   = (state_n == S_LOAD);
    win_valid_n  = (state_n == S_WIN);
    busy_n       = (state_n != S_IDLE);
    frame_done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lft        <= 8'd0;
      ctr        <= 8'd0;
      rgt        <= 8'd0;
      row        <= 8'd0;
      col        <= 8'd0;
      load_r     <= 1'b0;
      c          <= 2'b00;
      pix        <= 8'd0;
      in_ready   <= 1'b0;
      win_valid  <= 1'b0;
      win_col    <= 8'd0;
      win_row    <= 8'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      lft        <= lft_n;
      ctr        <= ctr_n;
      rgt        <= rgt_n;
      row        <= row_n;
      col        <= col_n;
      load_r     <= load_r_n;
      c          <= c_n;
      pix        <= pix_n;
      in_ready   <= in_ready_n;
      win_valid  <= win_valid_n;
      win_col    <= win_col_n;
      win_row    <= win_row_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_pad_conv_feeder.sv
// Bench for pad_conv_feeder: a 4x1 and a 4x2 instance share inputs; windows,
// timing and transfer counts are compared with a padded-window model.
module tb_pad_conv_feeder;

  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_pix;

  logic       a_in_ready, a_win_valid, a_busy, a_frame_done;
  logic [1:0] a_c;
  logic [7:0] a_pix, a_win_col, a_win_row;
  logic       b_in_ready, b_win_valid, b_busy, b_frame_done;
  logic [1:0] b_c;
  logic [7:0] b_pix, b_win_col, b_win_row;

  logic       sel;
  logic       m_in_ready, m_win_valid, m_busy, m_frame_done;
  logic [1:0] m_c;
  logic [7:0] m_pix, m_win_col, m_win_row;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame_px [0:7];
  int          frame_len;
  logic [23:0] got_buf [$];
  int          got_col [$];
  int          got_row [$];
  int          got_cyc [$];
  int          n_xfer, n_done, n_clr;
  bit          timed_out, stall_bad;

  always #5 clk = ~clk;

  pad_conv_feeder #(.IMG_W(W), .IMG_H(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .in_valid(in_valid),
    .in_ready(a_in_ready), .c(a_c), .pix(a_pix), .win_valid(a_win_valid),
    .win_col(a_win_col), .win_row(a_win_row), .busy(a_busy), .frame_done(a_frame_done));

  pad_conv_feeder #(.IMG_W(W), .IMG_H(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .in_valid(in_valid),
    .in_ready(b_in_ready), .c(b_c), .pix(b_pix), .win_valid(b_win_valid),
    .win_col(b_win_col), .win_row(b_win_row), .busy(b_busy), .frame_done(b_frame_done));

  assign m_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign m_win_valid  = sel ? b_win_valid  : a_win_valid;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_c          = sel ? b_c          : a_c;
  assign m_pix        = sel ? b_pix        : a_pix;
  assign m_win_col    = sel ? b_win_col    : a_win_col;
  assign m_win_row    = sel ? b_win_row    : a_win_row;

  // Zero-padded {left, centre, right} window centred on (r, k).
  function automatic logic [23:0] exp_win(input int r, input int k);
    logic [7:0] l, m, rt;
    l  = (k == 0)     ? 8'd0 : frame_px[r*W + k - 1];
    m  = frame_px[r*W + k];
    rt = (k == W - 1) ? 8'd0 : frame_px[r*W + k + 1];
    return {l, m, rt};
  endfunction

  // Cycle of window k after the start cycle with in_valid held high.
  function automatic int exp_cyc(input int k);
    int t = 0;
    for (int i = 0; i <= k; i++) begin
      if (i % W == 0)          t += 7;
      else if (i % W == W - 1) t += 4;
      else                     t += 5;
    end
    return t;
  endfunction

  // Drives one frame into the selected instance and records what it produced.
  task automatic run_frame(input bit do_rst, input bit rand_valid, input int stall_load,
                           input bit poke, input bit abort_wr1);
    logic [23:0] bm;
    logic        prev_ready;
    logic [1:0]  prev_c, hold_c;
    logic [7:0]  hold_pix;
    int          idx, cyc, loads, stall_left, done_cyc;
    bit          aborted;
    got_buf.delete(); got_col.delete(); got_row.delete(); got_cyc.delete();
    n_xfer = 0; n_done = 0; n_clr = 0; timed_out = 0; stall_bad = 0;
    bm = '0; idx = 0; loads = 0; stall_left = 0; done_cyc = -1;
    prev_ready = 1'b0; aborted = 0; hold_c = 2'b00; hold_pix = 8'd0;
    @(negedge clk);
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    prev_c = m_c;
    start = 1'b1; in_valid = 1'b0; cyc = 0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 400 && !aborted && (done_cyc < 0 || cyc < done_cyc + 3)) begin
      case (m_c)
        2'b00: bm[23:16] = m_pix;
        2'b10: bm[15:8]  = m_pix;
        2'b01: bm[7:0]   = m_pix;
        default: bm = '0;
      endcase
      if (m_c == 2'b11 && prev_c != 2'b11) n_clr++;
      prev_c = m_c;
      if (m_in_ready && !prev_ready) begin
        loads++;
        if (loads == stall_load) begin
          stall_left = 3; hold_c = m_c; hold_pix = m_pix;
        end
      end
      prev_ready = m_in_ready;
      if (stall_left > 0 && (m_c !== hold_c || m_pix !== hold_pix || m_in_ready !== 1'b1))
        stall_bad = 1;
      if (m_win_valid) begin
        got_buf.push_back(bm); got_col.push_back(int'(m_win_col));
        got_row.push_back(int'(m_win_row)); got_cyc.push_back(cyc);
      end
      if (m_frame_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_wr1 && m_c == 2'b10) begin
        rst = 1'b1; in_valid = 1'b0; aborted = 1;
      end else begin
        start = poke && m_busy && ($urandom_range(0, 3) == 0);
        if (stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = rand_valid ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
        in_pix = (idx < frame_len) ? frame_px[idx] : 8'($urandom);
        if (in_valid && m_in_ready) begin
          idx++; n_xfer++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (!aborted && done_cyc < 0) timed_out = 1;
  endtask

  task automatic load_ref_row();
    frame_len = 4;
    frame_px[0] = 8'h0A; frame_px[1] = 8'h14; frame_px[2] = 8'h1E; frame_px[3] = 8'h28;
    for (int i = 4; i < 8; i++) frame_px[i] = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pix = 8'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_c, a_pix, a_in_ready, a_win_valid, a_win_col, a_win_row, a_busy, a_frame_done} !== '0) begin
      n_fail++; $display("FAIL reset_a outputs got %h required 0",
        {a_c, a_pix, a_in_ready, a_win_valid, a_win_col, a_win_row, a_busy, a_frame_done});
    end
    n_checks++;
    if ({b_c, b_pix, b_in_ready, b_win_valid, b_win_col, b_win_row, b_busy, b_frame_done} !== '0) begin
      n_fail++; $display("FAIL reset_b outputs got %h required 0",
        {b_c, b_pix, b_in_ready, b_win_valid, b_win_col, b_win_row, b_busy, b_frame_done});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_busy, b_busy, a_in_ready, b_in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_no_start got %b required 0000", {a_busy, b_busy, a_in_ready, b_in_ready});
    end
  endtask

  task automatic test_basic(input bit do_rst);
    sel = 1'b0;
    load_ref_row();
    run_frame(do_rst, 1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || got_buf.size() != 4) begin
      n_fail++; $display("FAIL basic_windows got %0d (timeout %0d) required 4", got_buf.size(), timed_out);
    end
    for (int k = 0; k < got_buf.size() && k < 4; k++) begin
      n_checks++;
      if (got_buf[k] !== exp_win(0, k) || got_col[k] != k || got_row[k] != 0) begin
        n_fail++; $display("FAIL basic_win%0d got buf %h col %0d row %0d required %h col %0d row 0",
                           k, got_buf[k], got_col[k], got_row[k], exp_win(0, k), k);
      end
      n_checks++;
      if (got_cyc[k] != exp_cyc(k)) begin
        n_fail++; $display("FAIL basic_timing%0d got cycle %0d required %0d", k, got_cyc[k], exp_cyc(k));
      end
    end
    n_checks++;
    if (n_done != 1 || n_xfer != 4) begin
      n_fail++; $display("FAIL basic_done_xfer got done %0d xfer %0d required 1 4", n_done, n_xfer);
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    load_ref_row();
    run_frame(1'b1, 1'b0, 2, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || got_buf.size() != 4 || stall_bad) begin
      n_fail++; $display("FAIL stall_hold got windows %0d hold_err %0d timeout %0d required 4 0 0",
                         got_buf.size(), stall_bad, timed_out);
    end
    for (int k = 0; k < got_buf.size() && k < 4; k++) begin
      n_checks++;
      if (got_buf[k] !== exp_win(0, k) || got_cyc[k] != exp_cyc(k) + ((k >= 1) ? 3 : 0)) begin
        n_fail++; $display("FAIL stall_win%0d got %h at %0d required %h at %0d", k, got_buf[k],
                           got_cyc[k], exp_win(0, k), exp_cyc(k) + ((k >= 1) ? 3 : 0));
      end
    end
  endtask

  task automatic test_two_rows(input bit poke);
    sel = 1'b1;
    frame_len = 8;
    for (int i = 0; i < 8; i++) frame_px[i] = 8'($urandom);
    run_frame(1'b1, 1'b0, 0, poke, 1'b0);
    n_checks++;
    if (timed_out || got_buf.size() != 8 || n_xfer != 8 || n_done != 1 || n_clr != 2) begin
      n_fail++; $display("FAIL rows%0d_counts got win %0d xfer %0d done %0d clr %0d required 8 8 1 2",
                         poke, got_buf.size(), n_xfer, n_done, n_clr);
    end
    for (int k = 0; k < got_buf.size() && k < 8; k++) begin
      n_checks++;
      if (got_buf[k] !== exp_win(k / W, k % W) || got_col[k] != k % W || got_row[k] != k / W ||
          got_cyc[k] != exp_cyc(k)) begin
        n_fail++; $display("FAIL rows%0d_win%0d got %h c%0d r%0d @%0d required %h c%0d r%0d @%0d",
                           poke, k, got_buf[k], got_col[k], got_row[k], got_cyc[k],
                           exp_win(k / W, k % W), k % W, k / W, exp_cyc(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    load_ref_row();
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b1);
    n_checks++;
    if ({a_c, a_pix, a_in_ready, a_win_valid, a_win_col, a_win_row, a_busy, a_frame_done} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got %h required 0",
        {a_c, a_pix, a_in_ready, a_win_valid, a_win_col, a_win_row, a_busy, a_frame_done});
    end
    rst = 1'b0;
    test_basic(1'b0);
  endtask

  task automatic test_random();
    sel = 1'b1;
    frame_len = 8;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) frame_px[i] = 8'($urandom);
      run_frame(1'b1, 1'b1, 0, 1'b1, 1'b0);
      n_checks++;
      if (timed_out || got_buf.size() != 8 || n_xfer != 8 || n_done != 1) begin
        n_fail++; $display("FAIL rand%0d_counts got win %0d xfer %0d done %0d required 8 8 1",
                           it, got_buf.size(), n_xfer, n_done);
      end
      for (int k = 0; k < got_buf.size() && k < 8; k++) begin
        n_checks++;
        if (got_buf[k] !== exp_win(k / W, k % W) || got_col[k] != k % W || got_row[k] != k / W) begin
          n_fail++; $display("FAIL rand%0d_win%0d got %h c%0d r%0d required %h c%0d r%0d", it, k,
                             got_buf[k], got_col[k], got_row[k], exp_win(k / W, k % W), k % W, k / W);
        end
      end
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_basic(1'b1);
    test_stall();
    test_two_rows(1'b0);
    test_two_rows(1'b1);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_conv_feeder.md
PAD_CONV_FEEDER -- requirements
Module: pad_conv_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, pixels per row (2..255).
REQ-002 SHALL have parameter IMG_H, default 28, rows per frame (1..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle frame start request, honoured only in IDLE.
REQ-007 in_pix  input  8  raw pixel, row-major.
REQ-008 in_valid  input  1  in_pix valid.
REQ-009 in_ready  output  1  feeder accepts in_pix this cycle; transfer when in_valid & in_ready.
REQ-010 c  output  2  window-buffer write select: 00 top slot p[23:16], 10 mid slot p[15:8], 01 bottom slot p[7:0], 11 clear.
REQ-011 pix  output  8  byte written to window buffer.
REQ-012 win_valid  output  1  one-cycle pulse; buffer holds a complete 3-pixel window.
REQ-013 win_col  output  8  column index of the window centre, valid with win_valid.
REQ-014 win_row  output  8  row index, valid with win_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse after the last window of the frame.

Function
REQ-017 SHALL generate, for each row, IMG_W horizontal windows {left, centre, right} with zero padding: left=0 at col 0, right=0 at col IMG_W-1.
REQ-018 SHALL hold internal regs L, C, R (8 bits each).
REQ-019 States: IDLE, CLR, LOAD, WR0, WR1, WR2, WIN, DONE.
REQ-020 IDLE: start=1 -> CLR; row=0, col=0; otherwise stay IDLE.
REQ-021 CLR: c=11, pix=0; L<=0; -> LOAD needing 2 pixels.
REQ-022 LOAD: in_ready=1; each transfer fills C, then R; after the required count -> WR0; in_valid=0 stalls with no change.
REQ-023 WR0: c=00, pix=L; WR1: c=10, pix=C; WR2: c=01, pix=R; each one cycle, in sequence.
REQ-024 WIN: win_valid=1, win_col=col, win_row=row.
REQ-025 WIN with col<IMG_W-2: L<=C, C<=R, col+1; -> LOAD needing 1 pixel (into R).
REQ-026 WIN with col=IMG_W-2: L<=C, C<=R, R<=0, col+1; -> WR0 with no input accepted.
REQ-027 WIN with col=IMG_W-1: row<IMG_H-1 -> row+1, col=0, CLR; else -> DONE.
REQ-028 DONE: frame_done=1 for one cycle; -> IDLE.
REQ-029 c and pix SHALL be registered and valid during the state cycle that drives them; outside CLR/WR0-WR2 they SHALL hold their last driven values, so the buffer only rewrites an identical byte.
REQ-030 in_ready SHALL be 0 outside LOAD; SHALL accept exactly IMG_W pixels per row and IMG_W*IMG_H per frame.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 Timing with in_valid held 1: first win_valid 7 cycles after the start cycle; then windows every 5 cycles; the last window of a row comes 4 cycles after the previous one.

Reset
REQ-033 rst=1 at any clock edge SHALL force IDLE and zero c, pix, in_ready, win_valid, win_col, win_row, busy, frame_done, L, C, R, row and col; this includes mid-frame, and the partial frame is abandoned.
REQ-034 After rst is released, the first start SHALL begin a new frame from row 0.

Verification
REQ-035 IMG_W=4, IMG_H=1, row 0x0A,0x14,0x1E,0x28, in_valid always 1 -> buffer after each win_valid = 0x000A14, 0x0A141E, 0x141E28, 0x1E2800; win_col 0..3; frame_done once.
REQ-036 Same row, in_valid low for 3 cycles during the 2nd LOAD -> c/pix held and in_ready=1 throughout; identical window values, each window after the stall delayed 3 cycles.
REQ-037 IMG_W=4, IMG_H=2 -> c=11 before each row; 8 windows, win_row 0,0,0,0,1,1,1,1; exactly 8 input transfers.
REQ-038 start pulsed while busy -> no effect on the sequence or transfer count.
REQ-039 rst asserted during WR1 of row 0 -> next cycle all outputs 0 and IDLE; new start replays REQ-035 exactly.
REQ-040 Check timing with in_valid=1 -> first win_valid 7 cycles after start; spacing 5, 5, 4.
